// File: rtl/register_rename_stage_pkg.sv
// Shared parameters and types for the register rename stage.
package register_rename_stage_pkg;

  localparam int MAX_OPERANDS = 3;
  localparam int ARN_BITS     = 6;
  localparam int PRN_BITS     = 6;
  localparam int NUM_PRNS     = 1 << PRN_BITS;
  localparam int CNT_BITS     = PRN_BITS + 1;
  localparam int FU_COUNT     = 4;
  localparam int FUC_BITS     = $clog2(FU_COUNT);
  localparam int INST_ID_BITS = 6;
  localparam int NUM_ARNS     = 33;

  typedef logic [PRN_BITS-1:0]     prn_t;
  typedef logic [ARN_BITS-1:0]     arn_t;
  typedef logic [INST_ID_BITS-1:0] inst_id_t;
  typedef logic [CNT_BITS-1:0]     cnt_t;

  localparam arn_t ARN_NONE = 6'h3F;

  // An ARN takes part in renaming only if it names one of the renamed registers.
  function automatic logic arn_in_range(arn_t arn);
    return arn < ARN_BITS'(NUM_ARNS);
  endfunction

endpackage

// File: rtl/register_rename_stage_prn_free_list.sv
// Circular FIFO of free physical registers: up to MAX_OPERANDS pushes and pops
// per cycle. Pops read the current head, so PRNs pushed this cycle only become
// visible next cycle.
module prn_free_list
  import register_rename_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pop_count_i,
  input  logic       push_valid_i [MAX_OPERANDS],
  input  prn_t       push_prn_i   [MAX_OPERANDS],
  output prn_t       pop_prn_o    [MAX_OPERANDS],
  output cnt_t       count_o
);

  prn_t       mem_q [NUM_PRNS];
  prn_t       head_q;
  prn_t       tail_q;
  cnt_t       count_q;
  logic [1:0] push_off [MAX_OPERANDS];
  logic [1:0] npush;

  // Expose the next MAX_OPERANDS entries at the head.
  always_comb begin
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      pop_prn_o[k] = mem_q[prn_t'(head_q + prn_t'(k))];
    end
  end

  // Compact the valid push slots onto consecutive tail positions in slot order.
  always_comb begin
    npush = 2'd0;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      push_off[k] = npush;
      npush       = npush + {1'b0, push_valid_i[k]};
    end
  end

  // Storage, pointers and occupancy; reset loads PRNs NUM_ARNS..63 in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PRNS; i++) begin
        mem_q[i] <= (i < NUM_PRNS - NUM_ARNS) ? prn_t'(i + NUM_ARNS) : {PRN_BITS{1'b0}};
      end
      head_q  <= {PRN_BITS{1'b0}};
      tail_q  <= prn_t'(NUM_PRNS - NUM_ARNS);
      count_q <= cnt_t'(NUM_PRNS - NUM_ARNS);
    end else begin
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        if (push_valid_i[k]) begin
          mem_q[prn_t'(tail_q + prn_t'(push_off[k]))] <= push_prn_i[k];
        end
      end
      head_q  <= prn_t'(head_q + prn_t'(pop_count_i));
      tail_q  <= prn_t'(tail_q + prn_t'(npush));
      count_q <= cnt_t'(count_q + cnt_t'(npush) - cnt_t'(pop_count_i));
    end
  end

  assign count_o = count_q;

  prn_free_list_checker u_checker (
    .clk         (clk),
    .rst         (rst),
    .count_i     (count_q),
    .npush_i     (npush),
    .pop_count_i (pop_count_i)
  );

endmodule

// Protocol checks for the free list: the ROB never returns more PRNs than fit.
module prn_free_list_checker
  import register_rename_stage_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input cnt_t       count_i,
  input logic [1:0] npush_i,
  input logic [1:0] pop_count_i
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (int'(count_i) + int'(npush_i) - int'(pop_count_i)) <= NUM_PRNS)
    else $error("free list overflow");

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    int'(pop_count_i) <= int'(count_i))
    else $error("free list underflow");

endmodule

// File: rtl/register_rename_stage.sv
// Register rename stage: maps source ARNs to PRNs, allocates fresh PRNs for
// destinations and reports overwritten mappings to the ROB.
module register_rename_stage
  import register_rename_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [31:0]         in_raw_instr,
  input  logic [63:0]         in_instr_pc,
  input  logic [FUC_BITS-1:0] in_fu_choice,
  input  arn_t                arn_inputs          [MAX_OPERANDS],
  input  arn_t                arn_outputs         [MAX_OPERANDS],
  input  inst_id_t            new_inst_id,
  input  logic                free_valid          [MAX_OPERANDS],
  input  prn_t                free_prns           [MAX_OPERANDS],
  input  logic                set_prn_ready_valid [MAX_OPERANDS],
  input  prn_t                set_prn_ready       [MAX_OPERANDS],
  output logic                mapping_valid,
  output logic                mapping_valid_comb,
  output inst_id_t            inst_id,
  output logic [31:0]         raw_instr,
  output logic [63:0]         instr_pc,
  output logic [FUC_BITS-1:0] fu_choice,
  output logic                prn_input_valid     [MAX_OPERANDS],
  output logic                prn_input_ready     [MAX_OPERANDS],
  output prn_t                prn_input           [MAX_OPERANDS],
  output logic                prn_output_valid    [MAX_OPERANDS],
  output prn_t                prn_output          [MAX_OPERANDS],
  output logic                mapping_inputs_valid [MAX_OPERANDS],
  output prn_t                mapping_inputs_prn  [MAX_OPERANDS],
  output arn_t                mapping_inputs_arn  [MAX_OPERANDS]
);

  prn_t                remap_q [NUM_ARNS];
  prn_t                remap_d [NUM_ARNS];
  logic [NUM_PRNS-1:0] ready_q;
  logic [NUM_PRNS-1:0] ready_d;

  logic       src_ok  [MAX_OPERANDS];
  logic       dst_ok  [MAX_OPERANDS];
  prn_t       src_prn [MAX_OPERANDS];
  logic       src_rdy [MAX_OPERANDS];
  prn_t       new_prn [MAX_OPERANDS];
  prn_t       pop_prn [MAX_OPERANDS];
  logic [1:0] need;
  logic       accept;
  cnt_t       free_count;

  // Destination demand and acceptance; out-of-range destinations take no PRN
  // so a PRN can never be allocated without a mapping that later frees it.
  always_comb begin
    need = 2'd0;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      dst_ok[k] = arn_in_range(arn_outputs[k]);
      need      = need + {1'b0, dst_ok[k]};
    end
    accept = instr_valid && (free_count >= cnt_t'(need));
  end

  // Hand the popped PRNs to valid destination slots in ascending slot order.
  always_comb begin
    logic [1:0] run;
    run = 2'd0;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      if (dst_ok[k]) begin
        new_prn[k] = pop_prn[run];
        run        = run + 2'd1;
      end else begin
        new_prn[k] = {PRN_BITS{1'b0}};
      end
    end
  end

  // Source lookup against the pre-instruction table, with same-cycle ready bypass.
  always_comb begin
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      src_ok[k]  = arn_in_range(arn_inputs[k]);
      src_prn[k] = src_ok[k] ? remap_q[arn_inputs[k]] : {PRN_BITS{1'b0}};
      src_rdy[k] = ready_q[src_prn[k]];
      for (int j = 0; j < MAX_OPERANDS; j++) begin
        src_rdy[k] = src_rdy[k] | (set_prn_ready_valid[j] && (set_prn_ready[j] == src_prn[k]));
      end
      src_rdy[k] = src_rdy[k] && src_ok[k];
    end
  end

  // Overwritten mappings; a repeat of an ARN reports the lower slot's new PRN.
  always_comb begin
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      mapping_inputs_valid[k] = accept && dst_ok[k];
      mapping_inputs_arn[k]   = mapping_inputs_valid[k] ? arn_outputs[k] : {ARN_BITS{1'b0}};
      mapping_inputs_prn[k]   = dst_ok[k] ? remap_q[arn_outputs[k]] : {PRN_BITS{1'b0}};
      for (int j = 0; j < k; j++) begin
        if (dst_ok[j] && dst_ok[k] && (arn_outputs[j] == arn_outputs[k])) begin
          mapping_inputs_prn[k] = new_prn[j];
        end else begin
          mapping_inputs_prn[k] = mapping_inputs_prn[k];
        end
      end
      if (!mapping_inputs_valid[k]) begin
        mapping_inputs_prn[k] = {PRN_BITS{1'b0}};
      end else begin
        mapping_inputs_prn[k] = mapping_inputs_prn[k];
      end
    end
  end

  // Next remap and ready tables; higher slots win remaps, allocation clears win over sets.
  always_comb begin
    remap_d = remap_q;
    ready_d = ready_q;
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      if (set_prn_ready_valid[j]) ready_d[set_prn_ready[j]] = 1'b1;
      else                        ready_d = ready_d;
    end
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      if (accept && dst_ok[k]) begin
        remap_d[arn_outputs[k]] = new_prn[k];
        ready_d[new_prn[k]]     = 1'b0;
      end else begin
        remap_d = remap_d;
      end
    end
  end

  assign mapping_valid_comb = accept;

  prn_free_list u_free_list (
    .clk          (clk),
    .rst          (rst),
    .pop_count_i  (accept ? need : 2'd0),
    .push_valid_i (free_valid),
    .push_prn_i   (free_prns),
    .pop_prn_o    (pop_prn),
    .count_o      (free_count)
  );

  // Rename tables: identity mapping and all PRNs ready out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARNS; i++) remap_q[i] <= prn_t'(i);
      ready_q <= {NUM_PRNS{1'b1}};
    end else begin
      remap_q <= remap_d;
      ready_q <= ready_d;
    end
  end

  // Registered rename result; a dropped instruction leaves every field at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mapping_valid <= 1'b0;
      inst_id       <= {INST_ID_BITS{1'b0}};
      raw_instr     <= 32'h0;
      instr_pc      <= 64'h0;
      fu_choice     <= {FUC_BITS{1'b0}};
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        prn_input_valid[k]  <= 1'b0;
        prn_input_ready[k]  <= 1'b0;
        prn_input[k]        <= {PRN_BITS{1'b0}};
        prn_output_valid[k] <= 1'b0;
        prn_output[k]       <= {PRN_BITS{1'b0}};
      end
    end else begin
      mapping_valid <= accept;
      inst_id       <= accept ? new_inst_id : {INST_ID_BITS{1'b0}};
      raw_instr     <= accept ? in_raw_instr : 32'h0;
      instr_pc      <= accept ? in_instr_pc : 64'h0;
      fu_choice     <= accept ? in_fu_choice : {FUC_BITS{1'b0}};
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        prn_input_valid[k]  <= accept && src_ok[k];
        prn_input_ready[k]  <= accept && src_rdy[k];
        prn_input[k]        <= (accept && src_ok[k]) ? src_prn[k] : {PRN_BITS{1'b0}};
        prn_output_valid[k] <= accept && dst_ok[k];
        prn_output[k]       <= (accept && dst_ok[k]) ? new_prn[k] : {PRN_BITS{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_register_rename_stage.sv
// Directed bench for register_rename_stage with hand-computed expectations.
module tb_register_rename_stage;

  localparam logic [5:0] NONE = 6'h3F;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] in_raw_instr;
  logic [63:0] in_instr_pc;
  logic [1:0]  in_fu_choice;
  logic [5:0]  arn_inputs [3];
  logic [5:0]  arn_outputs [3];
  logic [5:0]  new_inst_id;
  logic        free_valid [3];
  logic [5:0]  free_prns [3];
  logic        set_prn_ready_valid [3];
  logic [5:0]  set_prn_ready [3];
  logic        mapping_valid, mapping_valid_comb;
  logic [5:0]  inst_id;
  logic [31:0] raw_instr;
  logic [63:0] instr_pc;
  logic [1:0]  fu_choice;
  logic        prn_input_valid [3];
  logic        prn_input_ready [3];
  logic [5:0]  prn_input [3];
  logic        prn_output_valid [3];
  logic [5:0]  prn_output [3];
  logic        mapping_inputs_valid [3];
  logic [5:0]  mapping_inputs_prn [3];
  logic [5:0]  mapping_inputs_arn [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  register_rename_stage dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .in_raw_instr(in_raw_instr),
    .in_instr_pc(in_instr_pc), .in_fu_choice(in_fu_choice), .arn_inputs(arn_inputs),
    .arn_outputs(arn_outputs), .new_inst_id(new_inst_id), .free_valid(free_valid),
    .free_prns(free_prns), .set_prn_ready_valid(set_prn_ready_valid), .set_prn_ready(set_prn_ready),
    .mapping_valid(mapping_valid), .mapping_valid_comb(mapping_valid_comb), .inst_id(inst_id),
    .raw_instr(raw_instr), .instr_pc(instr_pc), .fu_choice(fu_choice),
    .prn_input_valid(prn_input_valid), .prn_input_ready(prn_input_ready), .prn_input(prn_input),
    .prn_output_valid(prn_output_valid), .prn_output(prn_output),
    .mapping_inputs_valid(mapping_inputs_valid), .mapping_inputs_prn(mapping_inputs_prn),
    .mapping_inputs_arn(mapping_inputs_arn)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid  = 1'b0;
    in_raw_instr = 32'h0;
    in_instr_pc  = 64'h0;
    in_fu_choice = 2'd0;
    new_inst_id  = 6'd0;
    for (int k = 0; k < 3; k++) begin
      arn_inputs[k] = NONE;  arn_outputs[k] = NONE;
      free_valid[k] = 1'b0;  free_prns[k] = 6'd0;
      set_prn_ready_valid[k] = 1'b0;  set_prn_ready[k] = 6'd0;
    end
  endtask

  task automatic set_instr(input logic [5:0] s0, input logic [5:0] s1, input logic [5:0] s2,
                           input logic [5:0] d0, input logic [5:0] d1, input logic [5:0] d2,
                           input logic [5:0] id);
    instr_valid    = 1'b1;
    arn_inputs[0]  = s0; arn_inputs[1]  = s1; arn_inputs[2]  = s2;
    arn_outputs[0] = d0; arn_outputs[1] = d1; arn_outputs[2] = d2;
    new_inst_id    = id;
    in_raw_instr   = 32'hA000_0000 | {26'h0, id};
    in_instr_pc    = 64'h1000 + {58'h0, id};
    in_fu_choice   = id[1:0];
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (mapping_valid !== 1'b0) begin fails++; $display("FAIL reset_mv got %0d exp 0", mapping_valid); end
    tests++; if (prn_output_valid[0] !== 1'b0) begin fails++; $display("FAIL reset_pov got %0d exp 0", prn_output_valid[0]); end
    tests++; if (mapping_valid_comb !== 1'b0) begin fails++; $display("FAIL reset_mvc got %0d exp 0", mapping_valid_comb); end
  endtask

  task automatic test_basic();
    set_instr(6'd2, 6'd3, NONE, 6'd1, NONE, NONE, 6'd5);
    #1;
    tests++; if (mapping_valid_comb !== 1'b1) begin fails++; $display("FAIL basic_mvc got %0d exp 1", mapping_valid_comb); end
    tests++; if (mapping_inputs_valid[0] !== 1'b1 || mapping_inputs_arn[0] !== 6'd1 || mapping_inputs_prn[0] !== 6'd1)
      begin fails++; $display("FAIL basic_mapin got v%0d a%0d p%0d exp v1 a1 p1", mapping_inputs_valid[0], mapping_inputs_arn[0], mapping_inputs_prn[0]); end
    tests++; if (mapping_valid !== 1'b0) begin fails++; $display("FAIL basic_mv_early got %0d exp 0", mapping_valid); end
    tick();
    idle();
    tests++; if (mapping_valid !== 1'b1 || inst_id !== 6'd5) begin fails++; $display("FAIL basic_mv got %0d id %0d exp 1 id 5", mapping_valid, inst_id); end
    tests++; if (raw_instr !== 32'hA000_0005 || instr_pc !== 64'h1005 || fu_choice !== 2'd1)
      begin fails++; $display("FAIL basic_copy got %h %h %0d exp a0000005 1005 1", raw_instr, instr_pc, fu_choice); end
    tests++; if (prn_input[0] !== 6'd2 || prn_input[1] !== 6'd3 || prn_input_ready[0] !== 1'b1 || prn_input_ready[1] !== 1'b1)
      begin fails++; $display("FAIL basic_src got %0d %0d r%0d%0d exp 2 3 r11", prn_input[0], prn_input[1], prn_input_ready[0], prn_input_ready[1]); end
    tests++; if (prn_input_valid[2] !== 1'b0 || prn_input[2] !== 6'd0) begin fails++; $display("FAIL basic_src2 got v%0d p%0d exp v0 p0", prn_input_valid[2], prn_input[2]); end
    tests++; if (prn_output_valid[0] !== 1'b1 || prn_output[0] !== 6'd33) begin fails++; $display("FAIL basic_dst got v%0d p%0d exp v1 p33", prn_output_valid[0], prn_output[0]); end
    tick();
    tests++; if (mapping_valid !== 1'b0) begin fails++; $display("FAIL basic_mv_once got %0d exp 0", mapping_valid); end
  endtask

  // Continues from test_basic: x1 -> 33, next free PRN 34.
  task automatic test_back_to_back();
    set_instr(6'd2, NONE, NONE, 6'd1, NONE, NONE, 6'd6);
    #1;
    tests++; if (mapping_inputs_prn[0] !== 6'd33) begin fails++; $display("FAIL b2b_oldmap got %0d exp 33", mapping_inputs_prn[0]); end
    tick();
    tests++; if (prn_output[0] !== 6'd34) begin fails++; $display("FAIL b2b_dst1 got %0d exp 34", prn_output[0]); end
    set_instr(6'd1, NONE, NONE, 6'd4, NONE, NONE, 6'd7);
    tick();
    tests++; if (prn_input[0] !== 6'd34 || prn_input_ready[0] !== 1'b0)
      begin fails++; $display("FAIL b2b_dep got p%0d r%0d exp p34 r0", prn_input[0], prn_input_ready[0]); end
    tests++; if (prn_output[0] !== 6'd35) begin fails++; $display("FAIL b2b_dst2 got %0d exp 35", prn_output[0]); end
    set_instr(6'd4, NONE, NONE, 6'd6, NONE, NONE, 6'd8);
    set_prn_ready_valid[1] = 1'b1; set_prn_ready[1] = 6'd35;
    tick();
    idle();
    tests++; if (prn_input[0] !== 6'd35 || prn_input_ready[0] !== 1'b1)
      begin fails++; $display("FAIL b2b_bypass got p%0d r%0d exp p35 r1", prn_input[0], prn_input_ready[0]); end
    tests++; if (prn_output[0] !== 6'd36) begin fails++; $display("FAIL b2b_dst3 got %0d exp 36", prn_output[0]); end
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int i = 0; i < 31; i++) begin
      set_instr(NONE, NONE, NONE, 6'd10, NONE, NONE, 6'(i));
      #1;
      tests++; if (mapping_valid_comb !== 1'b1) begin fails++; $display("FAIL exh_accept_%0d got %0d exp 1", i, mapping_valid_comb); end
      tick();
      tests++; if (prn_output[0] !== 6'(33 + i)) begin fails++; $display("FAIL exh_prn_%0d got %0d exp %0d", i, prn_output[0], 33 + i); end
    end
    set_instr(NONE, NONE, NONE, 6'd11, NONE, NONE, 6'd40);
    free_valid[0] = 1'b1; free_prns[0] = 6'd1;
    #1;
    tests++; if (mapping_valid_comb !== 1'b0) begin fails++; $display("FAIL exh_drop_comb got %0d exp 0", mapping_valid_comb); end
    tick();
    idle();
    tests++; if (mapping_valid !== 1'b0 || prn_output_valid[0] !== 1'b0)
      begin fails++; $display("FAIL exh_drop_reg got mv%0d pv%0d exp 0 0", mapping_valid, prn_output_valid[0]); end
    set_instr(6'd11, 6'd10, NONE, NONE, NONE, NONE, 6'd41);
    tick();
    tests++; if (prn_input[0] !== 6'd11 || prn_input[1] !== 6'd63)
      begin fails++; $display("FAIL exh_noremap got %0d %0d exp 11 63", prn_input[0], prn_input[1]); end
    set_instr(NONE, NONE, NONE, 6'd11, NONE, NONE, 6'd42);
    #1;
    tests++; if (mapping_valid_comb !== 1'b1 || mapping_inputs_prn[0] !== 6'd11)
      begin fails++; $display("FAIL exh_retry_comb got %0d p%0d exp 1 p11", mapping_valid_comb, mapping_inputs_prn[0]); end
    tick();
    idle();
    tests++; if (mapping_valid !== 1'b1 || prn_output[0] !== 6'd1)
      begin fails++; $display("FAIL exh_retry got mv%0d p%0d exp 1 p1", mapping_valid, prn_output[0]); end
  endtask

  task automatic test_same_arn();
    do_reset();
    set_instr(NONE, NONE, NONE, 6'd5, 6'd5, NONE, 6'd9);
    #1;
    tests++; if (mapping_inputs_prn[0] !== 6'd5 || mapping_inputs_prn[1] !== 6'd33 || mapping_inputs_valid[1] !== 1'b1)
      begin fails++; $display("FAIL same_mapin got %0d %0d v%0d exp 5 33 v1", mapping_inputs_prn[0], mapping_inputs_prn[1], mapping_inputs_valid[1]); end
    tick();
    tests++; if (prn_output[0] !== 6'd33 || prn_output[1] !== 6'd34)
      begin fails++; $display("FAIL same_dst got %0d %0d exp 33 34", prn_output[0], prn_output[1]); end
    set_instr(6'd5, NONE, NONE, NONE, NONE, NONE, 6'd10);
    tick();
    tests++; if (prn_input[0] !== 6'd34) begin fails++; $display("FAIL same_read got %0d exp 34", prn_input[0]); end
  endtask

  // Continues from test_same_arn: next free PRN 35.
  task automatic test_src_dst_same();
    set_instr(6'd7, NONE, NONE, 6'd7, NONE, NONE, 6'd11);
    tick();
    tests++; if (prn_input[0] !== 6'd7 || prn_output[0] !== 6'd35)
      begin fails++; $display("FAIL srcdst got src%0d dst%0d exp 7 35", prn_input[0], prn_output[0]); end
    set_instr(6'd7, NONE, NONE, 6'd8, NONE, NONE, 6'd12);
    tick();
    idle();
    tests++; if (prn_input[0] !== 6'd35 || prn_input_ready[0] !== 1'b0)
      begin fails++; $display("FAIL srcdst_next got p%0d r%0d exp 35 r0", prn_input[0], prn_input_ready[0]); end
  endtask

  task automatic test_mid_reset();
    set_instr(NONE, NONE, NONE, 6'd9, NONE, NONE, 6'd13);
    tick();
    idle();
    tests++; if (mapping_valid !== 1'b1) begin fails++; $display("FAIL mrst_pre got %0d exp 1", mapping_valid); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (mapping_valid !== 1'b0 || prn_output_valid[0] !== 1'b0 || prn_output[0] !== 6'd0)
      begin fails++; $display("FAIL mrst_async got mv%0d pv%0d p%0d exp 0 0 0", mapping_valid, prn_output_valid[0], prn_output[0]); end
    tick();
    rst = 1'b0;
    set_instr(6'd5, 6'd7, NONE, 6'd9, NONE, NONE, 6'd14);
    #1;
    tests++; if (mapping_inputs_prn[0] !== 6'd9) begin fails++; $display("FAIL mrst_map got %0d exp 9", mapping_inputs_prn[0]); end
    tick();
    idle();
    tests++; if (prn_input[0] !== 6'd5 || prn_input[1] !== 6'd7 || prn_output[0] !== 6'd33)
      begin fails++; $display("FAIL mrst_state got %0d %0d %0d exp 5 7 33", prn_input[0], prn_input[1], prn_output[0]); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_back_to_back();
    test_exhaust();
    test_same_arn();
    test_src_dst_same();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
